seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered, multi-cycle successor to the combinational datapath ALU.
- Single-cycle ops finish in one clock. Shift-by-N and multiply iterate one step per clock.
- Start/Busy/Done handshake toward the controller; Zero/Carry/Branch flags are held until the next completion.
- Sits between the register file read ports and the writeback mux. The controller stalls on Busy.

Parameters:
- W, 8: data width (W >= 4).
- Ops, 4: opcode width.
- SHW, $clog2(W): shift-amount width, taken from InputB[SHW-1:0].

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only when Busy=0.
- OP  input  Ops  opcode (op_mne), sampled with Start.
- InputA  input  W  operand A, sampled with Start.
- InputB  input  W  operand B, sampled with Start.
- Out  output  W  registered result, held until the next completion.
- Branch  output  1  BNZ result, registered, valid when Done=1.
- Zero  output  1  flag: (Out==0), updated at completion.
- Carry  output  1  flag: carry / borrow / overflow, updated at completion.
- Busy  output  1  high while an iterative op is in progress.
- Done  output  1  one-cycle pulse in the cycle Out/flags become valid.

Behaviour:
- Reset (synchronous, active-high, Reset=1 at an edge):
  - state goes to IDLE.
  - Out, Branch, Zero, Carry, Busy and Done are all 0.
  - Reset dominates Start.
  - Reset mid-operation aborts the operation with no Done pulse.
- States: IDLE, RUN, DONE.
  - Start is accepted in IDLE or DONE, giving back-to-back ops.
  - Start is ignored in RUN.
  - Operands are latched at acceptance; later input changes have no effect.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, NEG, GEQ, EQ, NEQ, BNZ, unknown):
  - Start accepted at edge E0 → DONE.
  - Done=1 in the cycle after E0.
  - Busy is never asserted.
- Single-cycle op results:
  - ADD: Out = A+B mod 2^W; Carry = carry-out.
  - SUB: Out = A-B mod 2^W; Carry = 1 iff A<B unsigned (borrow).
  - AND/OR/XOR: bitwise; Carry=0.
  - NEG: Out = two's complement of A; Carry=0.
  - GEQ/EQ/NEQ: Out = {W-1 zeros, unsigned compare result}; Carry=0.
  - BNZ: Branch = (A!=0); Out=0. Branch is 0 after every other op.
  - Unknown opcode: Out=0, Carry=0, Zero=1.
- LSH / RSH / ASR by k = B[SHW-1:0]:
  - k=0: behaves as single-cycle; Out=A.
  - k>0: RUN with acc=A, cnt=k. Each RUN edge shifts acc by one and decrements cnt; when cnt=1 go to DONE.
  - Done high k+1 cycles after the accept cycle; Busy high for the k cycles in between.
  - LSH and RSH zero-fill; ASR replicates A[W-1].
  - Carry = last bit shifted out (0 when k=0).
- MUL (unsigned shift-add):
  - W iterations in RUN; Done at cycle W+1.
  - Out = low W bits of the product.
  - Carry = 1 iff the high W bits are nonzero.
  - Internal product register is 2W wide.
- Completion and flags:
  - Zero = (Out==0), evaluated on the new Out.
  - Flags change only at completion.
  - Done falls the cycle after DONE unless a new single-cycle op completes there.
  - DONE → IDLE when there is no Start.

Decomposition:
- Package definitions holds:
  - op_mne enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NEG=5, LSH=6, RSH=7, ASR=8, MUL=9, GEQ=10, EQ=11, NEQ=12, BNZ=13; 14–15 are NOP.
  - alu_state_t (IDLE/RUN/DONE).
  - helper function is_multicycle(op).
- One natural sub-module, alu_iter_unit:
  - holds the acc/product registers and counter for shifts and MUL.
  - interface: load, op, A, B in; step done / result / carry out.
- Top level owns the FSM, the single-cycle datapath and the flag registers.

Test Plan:
- ADD A=0xF0, B=0x20, Start 1 cycle → Done next cycle, Out=0x10, Carry=1, Zero=0, Busy=0 throughout.
- LSH A=0x81, B=3 → Busy cycles 1–3, Done cycle 4, Out=0x08, Carry=0. LSH A=0x81, B=0 → Done cycle 1, Out=0x81.
- MUL A=13, B=11 → Done cycle 9, Out=0x8F, Carry=0. MUL A=0x20, B=0x10 → Out=0x00, Carry=1, Zero=1.
- Start+ADD pulsed during MUL Busy → ignored, Out=MUL result. Start+SUB 3,5 in the Done cycle → accepted, next cycle Out=0xFE, Carry=1.
- Reset=1 in cycle 4 of a MUL → next cycle Busy=0, Done=0, Out=0, flags 0, no Done pulse. Following ASR A=0x80, B=2 → Out=0xE0 at cycle 3.
- BNZ A=0 → Branch=0, Out=0, Zero=1. BNZ A=5 → Branch=1. Opcode 15 → Out=0, Zero=1, Done cycle 1.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - opcode and state definitions shared by the sequential ALU
package seq_alu_pkg;

   localparam int OPW = 4;

   typedef enum logic [OPW-1:0] {
      ADD   = 4'd0,
      SUB   = 4'd1,
      AND   = 4'd2,
      OR    = 4'd3,
      XOR   = 4'd4,
      NEG   = 4'd5,
      LSH   = 4'd6,
      RSH   = 4'd7,
      ASR   = 4'd8,
      MUL   = 4'd9,
      GEQ   = 4'd10,
      EQ    = 4'd11,
      NEQ   = 4'd12,
      BNZ   = 4'd13,
      NOP14 = 4'd14,
      NOP15 = 4'd15
   } op_mne;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } alu_state_t;

   // Opcodes that may iterate; shifts by zero still finish in one cycle.
   function automatic logic is_multicycle(input op_mne op);
      return (op == LSH) || (op == RSH) || (op == ASR) || (op == MUL);
   endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// rtl/alu_iter_unit.sv - one-step-per-clock shifter and shift-add multiplier
module alu_iter_unit
   import seq_alu_pkg::*;
#(
   parameter int W   = 8,
   parameter int SHW = $clog2(W)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         step,
   input  op_mne        op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         last,
   output logic [W-1:0] result,
   output logic         carry
);

   // Counter must hold W (multiply iterations) as well as any shift amount.
   localparam int CW = SHW + 1;

   op_mne           op_q;
   logic [W-1:0]    acc_q;
   logic [W-1:0]    mcand_q;
   logic [2*W-1:0]  prod_q;
   logic [CW-1:0]   cnt_q;

   logic [W-1:0]    nxt_acc;
   logic            shout;
   logic [W:0]      sum;
   logic [2*W-1:0]  nxt_prod;

   // Value of the working registers after one more step, plus the bit leaving the shifter.
   always_comb begin
      nxt_acc = acc_q;
      shout   = 1'b0;
      case (op_q)
         LSH: begin
            nxt_acc = {acc_q[W-2:0], 1'b0};
            shout   = acc_q[W-1];
         end
         RSH: begin
            nxt_acc = {1'b0, acc_q[W-1:1]};
            shout   = acc_q[0];
         end
         ASR: begin
            nxt_acc = {acc_q[W-1], acc_q[W-1:1]};
            shout   = acc_q[0];
         end
         default: ;
      endcase
      // Multiplier bits sit in the low half and are consumed LSB first.
      sum      = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
      nxt_prod = {sum, prod_q[W-1:1]};
   end

   assign last   = (cnt_q == CW'(1));
   assign result = (op_q == MUL) ? nxt_prod[W-1:0] : nxt_acc;
   assign carry  = (op_q == MUL) ? (|nxt_prod[2*W-1:W]) : shout;

   // Load operands on acceptance, then advance one step per clock while the top is running.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q    <= ADD;
         acc_q   <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
      end else if (load) begin
         op_q    <= op;
         acc_q   <= a;
         mcand_q <= a;
         prod_q  <= {{W{1'b0}}, b};
         cnt_q   <= (op == MUL) ? CW'(W) : {1'b0, b[SHW-1:0]};
      end else if (step && (cnt_q != '0)) begin
         acc_q  <= nxt_acc;
         prod_q <= nxt_prod;
         cnt_q  <= cnt_q - CW'(1);
      end
   end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered multi-cycle ALU with start/busy/done handshake
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int W   = 8,
   parameter int Ops = 4,
   parameter int SHW = $clog2(W)
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic           Start,
   input  logic [Ops-1:0] OP,
   input  logic [W-1:0]   InputA,
   input  logic [W-1:0]   InputB,
   output logic [W-1:0]   Out,
   output logic           Branch,
   output logic           Zero,
   output logic           Carry,
   output logic           Busy,
   output logic           Done
);

   alu_state_t    state_q, state_d;
   op_mne         op;
   logic          accept;
   logic          multi;
   logic [W-1:0]  sc_res;
   logic          sc_carry;
   logic          sc_branch;
   logic          it_last;
   logic [W-1:0]  it_res;
   logic          it_carry;

   assign op     = op_mne'(OP[OPW-1:0]);
   // A shift by zero is handled by the single-cycle path.
   assign multi  = (op == MUL) || (is_multicycle(op) && (InputB[SHW-1:0] != '0));
   assign accept = Start && (state_q != RUN);
   assign Busy   = (state_q == RUN);
   assign Done   = (state_q == DONE);

   // Single-cycle datapath evaluated straight from the operands being accepted.
   always_comb begin
      sc_res    = '0;
      sc_carry  = 1'b0;
      sc_branch = 1'b0;
      case (op)
         ADD: {sc_carry, sc_res} = {1'b0, InputA} + {1'b0, InputB};
         SUB: begin
            sc_res   = InputA - InputB;
            sc_carry = (InputA < InputB);
         end
         AND: sc_res = InputA & InputB;
         OR:  sc_res = InputA | InputB;
         XOR: sc_res = InputA ^ InputB;
         NEG: sc_res = '0 - InputA;
         LSH, RSH, ASR: sc_res = InputA;
         GEQ: sc_res = {{(W-1){1'b0}}, (InputA >= InputB)};
         EQ:  sc_res = {{(W-1){1'b0}}, (InputA == InputB)};
         NEQ: sc_res = {{(W-1){1'b0}}, (InputA != InputB)};
         BNZ: sc_branch = (InputA != '0);
         default: ;
      endcase
   end

   // Next-state logic: DONE doubles as an accepting state for back-to-back ops.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: begin
            if (Start) state_d = multi ? RUN : DONE;
            else       state_d = IDLE;
         end
         RUN:     if (it_last) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge Clk) begin
      if (Reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Result and flags only move at completion and hold until the next one.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         Out    <= '0;
         Branch <= 1'b0;
         Zero   <= 1'b0;
         Carry  <= 1'b0;
      end else if (accept && !multi) begin
         Out    <= sc_res;
         Branch <= sc_branch;
         Zero   <= (sc_res == '0);
         Carry  <= sc_carry;
      end else if ((state_q == RUN) && it_last) begin
         Out    <= it_res;
         Branch <= 1'b0;
         Zero   <= (it_res == '0);
         Carry  <= it_carry;
      end
   end

   alu_iter_unit #(.W(W), .SHW(SHW)) u_iter (
      .clk    (Clk),
      .reset  (Reset),
      .load   (accept && multi),
      .step   (state_q == RUN),
      .op     (op),
      .a      (InputA),
      .b      (InputB),
      .last   (it_last),
      .result (it_res),
      .carry  (it_carry)
   );

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu
module tb_seq_alu;

   localparam logic [3:0] O_ADD = 4'd0,  O_SUB = 4'd1,  O_NEG = 4'd5,  O_LSH = 4'd6;
   localparam logic [3:0] O_ASR = 4'd8,  O_MUL = 4'd9,  O_GEQ = 4'd10, O_EQ  = 4'd11;
   localparam logic [3:0] O_BNZ = 4'd13, O_NOP = 4'd15;

   logic       clk = 1'b0;
   logic       reset, start;
   logic [3:0] op;
   logic [7:0] in_a, in_b;
   logic [7:0] out;
   logic       branch, zero, carry, busy, done;
   int         total = 0;
   int         bad   = 0;
   int         pulses;

   seq_alu #(.W(8), .Ops(4)) dut (
      .Clk    (clk),
      .Reset  (reset),
      .Start  (start),
      .OP     (op),
      .InputA (in_a),
      .InputB (in_b),
      .Out    (out),
      .Branch (branch),
      .Zero   (zero),
      .Carry  (carry),
      .Busy   (busy),
      .Done   (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request for exactly one edge, then scramble the operands.
   task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
      start = 1'b1;
      op    = o;
      in_a  = a;
      in_b  = b;
      tick();
      start = 1'b0;
      in_a  = ~a;
      in_b  = ~b;
      op    = O_ADD;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; start = 1'b0; op = O_ADD; in_a = '0; in_b = '0;
      tick();
      tick();
      chk("rst_out", out, 0);
      chk("rst_branch", branch, 0);
      chk("rst_zero", zero, 0);
      chk("rst_carry", carry, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      reset = 1'b0;
      tick();

      issue(O_ADD, 8'hF0, 8'h20);
      chk("add_done", done, 1);
      chk("add_busy", busy, 0);
      chk("add_out", out, 8'h10);
      chk("add_carry", carry, 1);
      chk("add_zero", zero, 0);
      tick();
      chk("add_done_fall", done, 0);
      chk("add_out_hold", out, 8'h10);

      issue(O_LSH, 8'h81, 8'd3);
      for (int c = 1; c <= 3; c++) begin
         chk("lsh_busy", busy, 1);
         chk("lsh_done_early", done, 0);
         tick();
      end
      chk("lsh_done", done, 1);
      chk("lsh_busy_end", busy, 0);
      chk("lsh_out", out, 8'h08);
      chk("lsh_carry", carry, 0);
      tick();

      issue(O_LSH, 8'h81, 8'd0);
      chk("lsh0_done", done, 1);
      chk("lsh0_busy", busy, 0);
      chk("lsh0_out", out, 8'h81);

      issue(O_MUL, 8'd13, 8'd11);
      for (int c = 1; c <= 8; c++) begin
         chk("mul_busy", busy, 1);
         chk("mul_done_early", done, 0);
         if (c == 3) begin
            start = 1'b1; op = O_ADD; in_a = 8'h01; in_b = 8'h01;
         end
         tick();
         start = 1'b0;
      end
      chk("mul_done", done, 1);
      chk("mul_out", out, 8'h8F);
      chk("mul_carry", carry, 0);

      issue(O_SUB, 8'd3, 8'd5);
      chk("sub_b2b_done", done, 1);
      chk("sub_out", out, 8'hFE);
      chk("sub_carry", carry, 1);
      tick();

      issue(O_MUL, 8'h20, 8'h10);
      repeat (8) tick();
      chk("mul2_done", done, 1);
      chk("mul2_out", out, 8'h00);
      chk("mul2_carry", carry, 1);
      chk("mul2_zero", zero, 1);
      tick();

      issue(O_MUL, 8'd13, 8'd11);
      repeat (3) tick();
      chk("abort_busy_before", busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_out", out, 0);
      chk("abort_zero", zero, 0);
      chk("abort_carry", carry, 0);
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         if (done) pulses++;
         tick();
      end
      chk("abort_no_done", pulses, 0);

      issue(O_ASR, 8'h80, 8'd2);
      chk("asr_busy1", busy, 1);
      tick();
      chk("asr_busy2", busy, 1);
      tick();
      chk("asr_done", done, 1);
      chk("asr_out", out, 8'hE0);
      chk("asr_carry", carry, 0);

      issue(O_BNZ, 8'd0, 8'd7);
      chk("bnz0_branch", branch, 0);
      chk("bnz0_out", out, 0);
      chk("bnz0_zero", zero, 1);
      issue(O_BNZ, 8'd5, 8'd0);
      chk("bnz5_branch", branch, 1);
      chk("bnz5_out", out, 0);
      issue(O_ADD, 8'd1, 8'd1);
      chk("branch_clear", branch, 0);
      chk("add2_out", out, 8'h02);

      issue(O_GEQ, 8'd5, 8'd5);
      chk("geq_out", out, 8'h01);
      issue(O_EQ, 8'd3, 8'd4);
      chk("eq_out", out, 8'h00);
      chk("eq_zero", zero, 1);
      issue(O_NEG, 8'd1, 8'd0);
      chk("neg_out", out, 8'hFF);
      chk("neg_carry", carry, 0);

      issue(O_NOP, 8'h55, 8'hAA);
      chk("nop_done", done, 1);
      chk("nop_out", out, 0);
      chk("nop_zero", zero, 1);
      chk("nop_carry", carry, 0);
      tick();
      chk("idle_done", done, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
